// File: rtl/div_int_pkg.sv
// Shared constants for the iterative integer divider: FSM encoding and a
// counter-width helper evaluated at elaboration time.
package div_int_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/div_int_step.sv
// One restoring-division step: shift {P,A} left by one, subtract D from the
// widened partial remainder when it fits, and shift the quotient bit into A.
module div_int_step #(
  parameter int W = 32
) (
  input  logic [W-1:0]   p,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   d,
  output logic [W-1:0]   p_nxt,
  output logic [2*W-1:0] a_nxt
);
  logic [W:0] ps;
  logic [W:0] diff;
  logic       ge;

  // P stays below D between steps, so the shifted value needs only one extra bit
  assign ps    = {p, a[2*W-1]};
  assign diff  = ps - {1'b0, d};
  assign ge    = ps >= {1'b0, d};
  assign p_nxt = ge ? diff[W-1:0] : ps[W-1:0];
  assign a_nxt = {a[2*W-2:0], ge};
endmodule

// File: rtl/div_int_iter.sv
// Iterative 2W/W signed/unsigned divider: one quotient bit per clock, fixed
// latency, separate divide-by-zero and overflow reporting.
module div_int_iter
  import div_int_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [2*W-1:0] dnd,
  input  logic [W-1:0]   der,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quo,
  output logic [W-1:0]   rem,
  output logic           err,
  output logic           dz
);
  localparam int CW = clog2(W);

  logic [1:0]     state;
  logic [CW-1:0]  count;
  logic           sgn_q, nnd, ner, dz_q, ovf_q;
  logic [W-1:0]   p, d, dnd_lo;
  logic [2*W-1:0] a;
  logic [W-1:0]   p_nxt;
  logic [2*W-1:0] a_nxt;
  logic [2*W-1:0] dnd_mag;
  logic [W-1:0]   der_mag;
  logic           qneg, sovf;
  logic [W-1:0]   q, r, lim;

  assign dnd_mag = (sgn && dnd[2*W-1]) ? -dnd : dnd;
  assign der_mag = (sgn && der[W-1]) ? -der : der;

  div_int_step #(.W(W)) u_step (
    .p(p), .a(a), .d(d), .p_nxt(p_nxt), .a_nxt(a_nxt)
  );

  // Negative quotients may reach 2^(W-1) in magnitude, positive ones one less
  always_comb begin
    qneg = nnd ^ ner;
    q    = a[W-1:0];
    r    = p;
    lim  = {1'b0, {(W-1){1'b1}}} + W'(qneg);
    sovf = sgn_q && (q > lim);
  end

  assign busy = (state != S_IDLE) || done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      done  <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      err   <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start && !done) begin
          state  <= S_RUN;
          count  <= '0;
          sgn_q  <= sgn;
          nnd    <= sgn & dnd[2*W-1];
          ner    <= sgn & der[W-1];
          d      <= der_mag;
          p      <= dnd_mag[2*W-1:W];
          a      <= {dnd_mag[W-1:0], {W{1'b0}}};
          dnd_lo <= dnd[W-1:0];
          dz_q   <= (der == '0);
          ovf_q  <= (dnd_mag[2*W-1:W] >= der_mag);
        end
        S_RUN: begin
          p     <= p_nxt;
          a     <= a_nxt;
          count <= count + 1'b1;
          if (count == CW'(W-1)) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          done  <= 1'b1;
          if (dz_q) begin
            err <= 1'b1;
            dz  <= 1'b1;
            quo <= '1;
            rem <= dnd_lo;
          end else if (ovf_q || sovf) begin
            err <= 1'b1;
            dz  <= 1'b0;
            quo <= '0;
            rem <= '0;
          end else begin
            err <= 1'b0;
            dz  <= 1'b0;
            quo <= qneg ? -q : q;
            rem <= nnd ? -r : r;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_int_iter.sv
// Scoreboard bench for div_int_iter: directed corner cases, handshake and
// reset scenarios, plus randomized operands against a wide-arithmetic model.
module tb_div_int_iter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, start, sgn;
  logic [2*W-1:0] dnd;
  logic [W-1:0]   der;
  logic           busy, done, err, dz;
  logic [W-1:0]   quo, rem;

  div_int_iter #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .dnd(dnd), .der(der),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .err(err), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         err;
    logic         dz;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: exact quotient/remainder in 128-bit arithmetic, then range check
  function automatic exp_t model(input logic s, input logic [2*W-1:0] n, input logic [W-1:0] r);
    exp_t e;
    logic signed [127:0] sd, sv, sq, srm;
    logic [127:0]        uq, ur;
    logic signed [127:0] qmax, qmin;
    e.acc = 0;
    qmax = 128'sd2147483647;
    qmin = -128'sd2147483648;
    if (r == '0) begin
      e.err = 1'b1; e.dz = 1'b1; e.quo = '1; e.rem = n[W-1:0];
    end else if (!s) begin
      uq = {64'd0, n} / {96'd0, r};
      ur = {64'd0, n} % {96'd0, r};
      e.dz = 1'b0;
      if (uq >= 128'h1_0000_0000) begin
        e.err = 1'b1; e.quo = '0; e.rem = '0;
      end else begin
        e.err = 1'b0; e.quo = uq[W-1:0]; e.rem = ur[W-1:0];
      end
    end else begin
      sd  = $signed(n);
      sv  = $signed(r);
      sq  = sd / sv;
      srm = sd % sv;
      e.dz = 1'b0;
      if (sq > qmax || sq < qmin) begin
        e.err = 1'b1; e.quo = '0; e.rem = '0;
      end else begin
        e.err = 1'b0; e.quo = sq[W-1:0]; e.rem = srm[W-1:0];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("quo", 64'(quo), 64'(e.quo));
        chk("rem", 64'(rem), 64'(e.rem));
        chk("err", 64'(err), 64'(e.err));
        chk("dz", 64'(dz), 64'(e.dz));
        chk("latency", 64'(cyc - e.acc), 64'(W + 1));
        chk("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic issue(input logic s, input logic [2*W-1:0] n, input logic [W-1:0] r);
    exp_t e;
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("issue_timeout", 64'd1, 64'd0);
    sgn = s; dnd = n; der = r; start = 1'b1;
    e = model(s, n, r);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.acc = cyc;
    sb.push_back(e);
    sgn = ~s; dnd = {$urandom, $urandom}; der = $urandom;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("drain_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] lo, hi, r;
    logic         s;
    int           t;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; dnd = '0; der = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_outs", {quo, rem} | 64'({err, dz}), 64'd0);

    issue(1'b0, 64'd100, 32'd7);
    issue(1'b1, 64'(-100), 32'd7);
    issue(1'b1, 64'd100, 32'(-7));
    issue(1'b1, 64'(-100), 32'(-7));
    issue(1'b0, 64'd5, 32'd0);
    issue(1'b0, 64'h1_0000_0000, 32'd1);
    issue(1'b1, 64'(-64'sd2147483648), 32'(-1));
    issue(1'b1, 64'(-64'sd2147483648), 32'd1);
    issue(1'b0, 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Handshake: starts while busy and in the done cycle are both dropped
    issue(1'b0, 64'd1000, 32'd9);
    repeat (3) @(negedge clk);
    start = 1'b1; dnd = 64'd77; der = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done !== 1'b1 && t < 100);
    if (t >= 100) chk("done_timeout", 64'd1, 64'd0);
    start = 1'b1; dnd = 64'd50; der = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    chk("idle_after_done", 64'(busy), 64'd0);
    issue(1'b0, 64'd50, 32'd5);
    drain();

    // Reset in the middle of RUN aborts without a done
    issue(1'b0, 64'd12345, 32'd17);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quo_rem", {quo, rem}, 64'd0);
    chk("abort_flags", 64'({err, dz}), 64'd0);
    repeat (W + 5) @(negedge clk);
    issue(1'b1, 64'(-12345), 32'd17);
    drain();

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      lo = $urandom; hi = $urandom; r = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: hi = {W{lo[W-1]}};
        2: hi = $urandom_range(0, 3);
        default: begin
          hi = {W{lo[W-1]}};
          r = $urandom_range(0, 3);
          if ($urandom_range(0, 1) == 1) r = -r;
        end
      endcase
      issue(s, {hi, lo}, r);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
